wb_arbiter: RTL

Write-back arbiter for the single register-file write port (`A3`/`WD3`/`WE3`). It merges the ALU result stream, which is never back-pressured, with late load responses, which use a valid/ready handshake. Load responses wait in a small FIFO and drain into free write slots. A newer ALU write to the same destination squashes any pending, older load data for that register.

---
 rtl/wb_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_arbiter : register-file write-back arbiter; ALU writes win the slot,    |
// |              late loads queue in a FIFO and drain into free cycles.        |
// | Option     : WB_LD_BYPASS_EN lets a load skip an empty buffer.             |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ALU_VALID,
    input  logic [4:0]               ALU_RD,
    input  logic [31:0]              ALU_RES,
    input  logic                     LD_VALID,
    output logic                     LD_READY,
    input  logic [4:0]               LD_RD,
    input  logic [31:0]              LD_DATA,
    output logic [4:0]               A3,
    output logic [31:0]              WD3,
    output logic                     WE3,
    output logic                     BUSY,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [4:0]    r_rd   [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic          r_live [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_we3;
    logic [4:0]    r_a3;
    logic [31:0]   r_wd3;

    logic          w_alu_sel;
    logic          w_ld_acc;
    logic          w_empty;
    logic          w_bypass;
    logic          w_push;
    logic          w_push_live;
    logic          w_pop;

    assign LD_READY    = !RST && (r_count < c_depth);
    assign w_alu_sel   = ALU_VALID && (ALU_RD != 5'd0);
    assign w_ld_acc    = LD_VALID && LD_READY;
    assign w_empty     = (r_count == '0);

`ifdef WB_LD_BYPASS_EN
    assign w_bypass    = w_empty && !w_alu_sel && w_ld_acc && (LD_RD != 5'd0);
`else
    assign w_bypass    = 1'b0;
`endif

    assign w_push      = w_ld_acc && (LD_RD != 5'd0) && !w_bypass;
    // A same-cycle load is older than the selected ALU write, so it enters dead.
    assign w_push_live = !(w_alu_sel && (LD_RD == ALU_RD));
    assign w_pop       = !w_alu_sel && !w_empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_we3   <= 1'b0;
            r_a3    <= 5'd0;
            r_wd3   <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_live[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alu_sel && (r_rd[i] == ALU_RD)) begin
                    r_live[i] <= 1'b0;
                end
            end

            // The tail slot is free whenever a push happens, so this overrides any squash above.
            if (w_push) begin
                r_rd[r_tail]   <= LD_RD;
                r_data[r_tail] <= LD_DATA;
                r_live[r_tail] <= w_push_live;
                r_tail         <= r_tail + 1'b1;
            end

            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_alu_sel) begin
                r_we3 <= 1'b1;
                r_a3  <= ALU_RD;
                r_wd3 <= ALU_RES;
            end else if (w_pop) begin
                r_we3 <= r_live[r_head];
                r_a3  <= r_rd[r_head];
                r_wd3 <= r_data[r_head];
            end else if (w_bypass) begin
                r_we3 <= 1'b1;
                r_a3  <= LD_RD;
                r_wd3 <= LD_DATA;
            end else begin
                r_we3 <= 1'b0;
            end
        end
    end

    assign WE3   = r_we3;
    assign A3    = r_a3;
    assign WD3   = r_wd3;
    assign COUNT = r_count;
    assign BUSY  = (r_count != '0);

endmodule
`default_nettype wire
